// File: rtl/ptw_rr_arb_if.sv
// Handshake and payload bundle between the TLB requesters, the PTW and the
// round-robin walker arbiter. The arbiter binds to the slave modport; the
// environment (requesters plus PTW) drives through the master modport.
interface ptw_rr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 64,
    parameter int RESP_W  = 64
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*REQ_W-1:0] req_data;

    logic                     ptw_req_valid;
    logic                     ptw_req_ready;
    logic [REQ_W-1:0]         ptw_req_data;
    logic [ID_W-1:0]          ptw_req_id;

    logic                     ptw_resp_valid;
    logic [RESP_W-1:0]        ptw_resp_data;

    logic [NUM_REQ-1:0]       resp_valid;
    logic [RESP_W-1:0]        resp_data;

    modport slave (
        input  req_valid, req_data, ptw_req_ready, ptw_resp_valid, ptw_resp_data,
        output req_ready, ptw_req_valid, ptw_req_data, ptw_req_id, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_data, ptw_req_ready, ptw_resp_valid, ptw_resp_data,
        input  req_ready, ptw_req_valid, ptw_req_data, ptw_req_id, resp_valid, resp_data
    );
endinterface

// File: rtl/ptw_rr_arb.sv
// Round-robin page-table-walker arbiter: one buffered request per TLB
// requester, a single walk in flight, responses routed to the originator.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no walk in flight; pick next occupied slot from rr_ptr
// ISSUE     | presenting granted slot to the PTW until it accepts
// WAIT_RESP | walk in flight; response goes to the granted requester
// DRAIN     | walk flushed while in flight; swallow its response
module ptw_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 64,
    parameter int RESP_W  = 64
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               flush_i,
    ptw_rr_arb_if.slave        bus,
    output logic               busy_o
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DRAIN     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] slot_vld_q;
    logic [REQ_W-1:0]   slot_data_q [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;

    logic               found;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    rr_next;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] clr_vec;
    logic               deliver;

    assign grant_oh = NUM_REQ'(1) << grant_q;
    // A response coincident with flush belongs to an aborted walk and is dropped.
    assign deliver  = (state_q == WAIT_RESP) & bus.ptw_resp_valid & ~flush_i;
    assign clr_vec  = deliver ? grant_oh : '0;
    assign accept   = bus.req_valid & bus.req_ready;
    assign rr_next  = (pick == LAST_IDX) ? '0 : pick + 1'b1;

    assign bus.req_ready     = ~slot_vld_q & {NUM_REQ{~flush_i}};
    assign bus.ptw_req_valid = (state_q == ISSUE) & ~flush_i;
    assign bus.ptw_req_data  = slot_data_q[grant_q];
    assign bus.ptw_req_id    = grant_q;
    assign bus.resp_valid    = clr_vec;
    assign bus.resp_data     = bus.ptw_resp_data;
    assign busy_o            = (state_q != IDLE) | (|slot_vld_q);

    // First occupied slot at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!found && slot_vld_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && found) begin
                    state_d  = ISSUE;
                    grant_d  = pick;
                    rr_ptr_d = rr_next;
                end
            end
            ISSUE: begin
                if (flush_i)                state_d = IDLE;
                else if (bus.ptw_req_ready) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (flush_i)                 state_d = bus.ptw_resp_valid ? IDLE : DRAIN;
                else if (bus.ptw_resp_valid) state_d = IDLE;
            end
            DRAIN: begin
                if (bus.ptw_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant index and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Per-requester slots: load on handshake, free on delivery, wipe on flush.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_vld_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot_data_q[i] <= '0;
        end else begin
            if (flush_i) slot_vld_q <= '0;
            else         slot_vld_q <= (slot_vld_q | accept) & ~clr_vec;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) slot_data_q[i] <= bus.req_data[i*REQ_W +: REQ_W];
            end
        end
    end
endmodule

// File: tb/tb_ptw_rr_arb.sv
// Directed bench for ptw_rr_arb: expected PTW requests and TLB responses
// are queued by the stimulus and checked by independent monitors.
module tb_ptw_rr_arb;
    localparam int NUM_REQ = 4;
    localparam int REQ_W   = 64;
    localparam int RESP_W  = 64;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [REQ_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] oh;
        logic [RESP_W-1:0]  data;
    } resp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    req_t  exp_req_q[$];
    resp_t exp_resp_q[$];
    req_t  er;
    resp_t ep;

    ptw_rr_arb_if #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .RESP_W(RESP_W)) bus ();

    ptw_rr_arb #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .RESP_W(RESP_W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .flush_i(flush),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // PTW request monitor: every accepted request must match the next expected grant.
    always @(negedge clk) begin
        if (rstn && bus.ptw_req_valid && bus.ptw_req_ready) begin
            if (exp_req_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ptw_req: got id %0d data 0x%0h, expected none",
                         bus.ptw_req_id, bus.ptw_req_data);
            end else begin
                er = exp_req_q.pop_front();
                chk("ptw_req_id", 64'(bus.ptw_req_id), 64'(er.id));
                chk("ptw_req_data", bus.ptw_req_data, er.data);
            end
        end
    end

    // Response monitor: every strobe must match the next expected routed response.
    always @(negedge clk) begin
        if (rstn && bus.resp_valid != '0) begin
            if (exp_resp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got strobe 0x%0h data 0x%0h, expected none",
                         bus.resp_valid, bus.resp_data);
            end else begin
                ep = exp_resp_q.pop_front();
                chk("resp_valid", 64'(bus.resp_valid), 64'(ep.oh));
                chk("resp_data", bus.resp_data, ep.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn               = 1'b0;
        flush              = 1'b0;
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.ptw_req_ready  = 1'b0;
        bus.ptw_resp_valid = 1'b0;
        bus.ptw_resp_data  = '0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic set_req(input int i, input logic [REQ_W-1:0] d);
        bus.req_valid[i]             = 1'b1;
        bus.req_data[i*REQ_W +: REQ_W] = d;
    endtask

    task automatic send();
        tick();
        bus.req_valid = '0;
    endtask

    task automatic exp_req(input int id, input logic [REQ_W-1:0] d);
        exp_req_q.push_back('{id: ID_W'(id), data: d});
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ptw_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: ptw_req_valid got 0 after 40 cycles, expected 1");
        end
    endtask

    task automatic handshake(output bit ok);
        wait_issue(ok);
        if (ok) begin
            bus.ptw_req_ready = 1'b1;
            tick();
            bus.ptw_req_ready = 1'b0;
        end
    endtask

    task automatic walk(input logic [NUM_REQ-1:0] oh, input logic [RESP_W-1:0] rd);
        bit ok;
        handshake(ok);
        if (ok) begin
            exp_resp_q.push_back('{oh: oh, data: rd});
            bus.ptw_resp_valid = 1'b1;
            bus.ptw_resp_data  = rd;
            tick();
            bus.ptw_resp_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'hF);
        chk({tag, "_ptw_valid"}, 64'(bus.ptw_req_valid), 64'h0);
        chk({tag, "_ptw_id"}, 64'(bus.ptw_req_id), 64'h0);
        chk({tag, "_ptw_data"}, bus.ptw_req_data, 64'h0);
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no summary within time limit, expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;

        // Single request, minimum latency, routed response.
        do_reset();
        chk_reset_outputs("rst");
        set_req(1, 64'hA5);
        send();
        chk("lat_e0_valid", 64'(bus.ptw_req_valid), 64'h0);
        chk("lat_e0_busy", 64'(busy), 64'h1);
        tick();
        chk("lat_e1_valid", 64'(bus.ptw_req_valid), 64'h1);
        exp_req(1, 64'hA5);
        walk(4'b0010, 64'h1234);
        chk("slot1_freed", 64'(bus.req_ready[1]), 64'h1);

        // All four at once: order 0,1,2,3 then idle.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 64'h100 + 64'(i));
            exp_req(i, 64'h100 + 64'(i));
        end
        send();
        chk("all_slots_taken", 64'(bus.req_ready), 64'h0);
        for (int i = 0; i < NUM_REQ; i++) begin
            walk(NUM_REQ'(1) << i, 64'hB000 + 64'(i));
            chk("busy_after_walk", 64'(busy), (i < NUM_REQ - 1) ? 64'h1 : 64'h0);
        end

        // Requester 0 keeps re-requesting; requester 2 must still be served.
        do_reset();
        set_req(0, 64'h100);
        set_req(2, 64'h200);
        send();
        exp_req(0, 64'h100);
        exp_req(2, 64'h200);
        exp_req(0, 64'h101);
        exp_req(2, 64'h201);
        walk(4'b0001, 64'hC0);
        set_req(0, 64'h101);
        send();
        walk(4'b0100, 64'hC1);
        set_req(2, 64'h201);
        send();
        walk(4'b0001, 64'hC2);
        walk(4'b0100, 64'hC3);

        // PTW backpressure: request held stable, accepted once.
        do_reset();
        set_req(3, 64'h3C3C);
        send();
        exp_req(3, 64'h3C3C);
        wait_issue(ok);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(bus.ptw_req_valid), 64'h1);
            chk("stall_id", 64'(bus.ptw_req_id), 64'h3);
            chk("stall_data", bus.ptw_req_data, 64'h3C3C);
            tick();
        end
        walk(4'b1000, 64'h77);
        chk("stall_done_valid", 64'(bus.ptw_req_valid), 64'h0);

        // Flush in WAIT_RESP: slots wiped, late response swallowed.
        do_reset();
        set_req(1, 64'h11);
        set_req(3, 64'h33);
        send();
        exp_req(1, 64'h11);
        handshake(ok);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 64'(bus.req_ready), 64'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_slots_cleared", 64'(bus.req_ready), 64'hF);
        chk("drain_busy", 64'(busy), 64'h1);
        bus.ptw_resp_valid = 1'b1;
        bus.ptw_resp_data  = 64'hDEAD;
        #1;
        chk("drain_resp_dropped", 64'(bus.resp_valid), 64'h0);
        tick();
        bus.ptw_resp_valid = 1'b0;
        chk("drain_done_busy", 64'(busy), 64'h0);
        repeat (3) tick();
        chk("flush_no_regrant", 64'(bus.ptw_req_valid), 64'h0);

        // Flush coincident with the response: dropped, straight to IDLE, rr_ptr kept.
        do_reset();
        set_req(1, 64'h11);
        set_req(3, 64'h33);
        send();
        exp_req(1, 64'h11);
        handshake(ok);
        flush              = 1'b1;
        bus.ptw_resp_valid = 1'b1;
        bus.ptw_resp_data  = 64'hBEEF;
        #1;
        chk("coinc_resp_dropped", 64'(bus.resp_valid), 64'h0);
        tick();
        flush              = 1'b0;
        bus.ptw_resp_valid = 1'b0;
        #1;
        chk("coinc_no_drain", 64'(busy), 64'h0);
        set_req(0, 64'hA0);
        set_req(3, 64'hA3);
        send();
        exp_req(3, 64'hA3);
        exp_req(0, 64'hA0);
        walk(4'b1000, 64'h5);
        walk(4'b0001, 64'h6);

        // Reset while a walk is in flight; later response ignored.
        do_reset();
        set_req(2, 64'h22);
        send();
        exp_req(2, 64'h22);
        handshake(ok);
        rstn = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'h0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        bus.ptw_resp_valid = 1'b1;
        bus.ptw_resp_data  = 64'h99;
        #1;
        chk_reset_outputs("post_rst");
        tick();
        bus.ptw_resp_valid = 1'b0;
        repeat (2) tick();

        chk("exp_req_drained", 64'(exp_req_q.size()), 64'h0);
        chk("exp_resp_drained", 64'(exp_resp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ptw_rr_arb.md
Name: ptw_rr_arb

Overview:
- Parametrised page-table-walker arbiter, successor to the two-port iTLB/dTLB arbiter.
- Sits between NUM_REQ TLB-side requesters (iTLB, dTLB, vector/prefetch TLBs) and a single PTW.
- Buffers one request per requester and grants the PTW round-robin.
- Routes each response back to its originator only; supports flush with in-flight drain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_W, 64, request payload width (VPN + access-type bits, opaque to this block)
RESP_W, 64, response payload width (PTE + fault/level bits, opaque)
ID_W, $clog2(NUM_REQ), grant index width (derived, do not override)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
flush_i  in  1  sfence/satp-change: abort all buffered and in-flight walks
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester slot free
req_data_i  in  NUM_REQ*REQ_W  per-requester payload; requester i occupies bits [i*REQ_W +: REQ_W]
ptw_req_valid_o  out  1  request to PTW
ptw_req_ready_i  in  1  PTW accepts request
ptw_req_data_o  out  REQ_W  granted payload
ptw_req_id_o  out  ID_W  granted requester index
ptw_resp_valid_i  in  1  PTW walk complete (single-cycle pulse)
ptw_resp_data_i  in  RESP_W  PTW result
resp_valid_o  out  NUM_REQ  one-hot response strobe
resp_data_o  out  RESP_W  response payload (broadcast, qualify with resp_valid_o)
busy_o  out  1  state != IDLE or any slot occupied

Behaviour:
- Reset values: all slots empty, rr_ptr=0, state IDLE. Outputs: req_ready_o=all 1s, ptw_req_valid_o=0, ptw_req_id_o=0, ptw_req_data_o=0, resp_valid_o=0, busy_o=0.
- Slot i: req_ready_o[i] = ~slot_vld[i] & ~flush_i.
  - On valid&ready at edge E, slot i loads req_data_i and becomes occupied from E.
  - Slot i frees on the edge its response is delivered or on flush.
  - Requester i therefore has at most one outstanding walk.
- Arbitration: in IDLE, search occupied slots starting at rr_ptr, incrementing with wrap modulo NUM_REQ; the first hit k is granted.
  - On grant, state moves to ISSUE, the latched grant index becomes k, and rr_ptr becomes (k+1) mod NUM_REQ.
  - No grant if no slot is occupied.
  - Minimum latency: request accepted at E0, grant at E1, ptw_req_valid_o high in the cycle after E1.
- FSM:
  - IDLE -> ISSUE on grant.
  - ISSUE: ptw_req_valid_o=1. ptw_req_data_o, ptw_req_id_o come from registered grant and slot, stable until accepted. On ptw_req_ready_i -> WAIT_RESP.
  - WAIT_RESP: ptw_req_valid_o=0. On ptw_resp_valid_i, resp_valid_o[grant]=1 in the same cycle (combinational route), resp_data_o=ptw_resp_data_i, slot[grant] cleared, -> IDLE.
  - DRAIN: wait for ptw_resp_valid_i, discard it (resp_valid_o stays 0) -> IDLE.
- No re-grant in the cycle of response; the next grant is decided in IDLE the cycle after, so there is 1 idle cycle between walks.
- Response in IDLE/ISSUE/DRAIN-outside-expectation (protocol error): ignored, resp_valid_o stays 0.
- Flush (priority over everything):
  - All slots cleared at the next edge; req_ready_o=0 while flush_i high.
  - IDLE or ISSUE -> IDLE (ptw_req_valid_o drops; PTW is flushed by the same signal).
  - WAIT_RESP -> DRAIN.
  - A ptw_resp_valid_i coincident with flush_i in WAIT_RESP is dropped: no resp_valid_o, state -> IDLE, not DRAIN.
  - rr_ptr is unchanged by flush.
- Simultaneous requests: all accepted in the same edge (independent slots); service order is determined solely by rr_ptr.
- Reset mid-operation: immediate return to reset values; any pending PTW response after reset is ignored (state IDLE).

Test Plan:
- NUM_REQ=4, single req1 data 0xA5 at E0, ptw_req_ready_i=1 -> ptw_req_valid_o high after E1, id=1, data=0xA5. Resp 0x1234 -> resp_valid_o=4'b0010, resp_data_o=0x1234 same cycle; req_ready_o[1]=1 next cycle.
- All 4 request in the same cycle after reset -> grant order 0,1,2,3; each gets only its own resp_valid_o bit; busy_o falls after the 4th response.
- Requester 0 re-requests immediately after every response while req 2 is pending -> grants alternate 0,2,0,2 (no starvation); rr_ptr wraps 3->0 correctly.
- ptw_req_ready_i held low 5 cycles in ISSUE -> ptw_req_valid_o, data, id stable all 5 cycles; single handshake on release.
- Flush in WAIT_RESP with slots 1,3 occupied -> slots cleared, req_ready_o=0 during flush, next PTW response swallowed (resp_valid_o=0), state IDLE. Second variant: flush coincident with the response -> also swallowed, no DRAIN.
- Assert rstn_i low during WAIT_RESP, release, then pulse ptw_resp_valid_i -> all outputs at reset values, no resp_valid_o.
